// File: rtl/font_rom_arbiter_if.sv
// Shared font ROM port bundle: video lookup, CPU read and ROM address/data.
// The arbiter takes the slave view; clients and the ROM model take the master view.
interface font_rom_arbiter_if;
  logic        vid_req_i;
  logic [10:0] vid_addr_i;
  logic        vid_valid_o;
  logic [15:0] vid_data_o;
  logic        vid_drop_o;
  logic        cpu_req_i;
  logic [10:0] cpu_addr_i;
  logic        cpu_ack_o;
  logic [15:0] cpu_data_o;
  logic [7:0]  drop_cnt_o;
  logic [10:0] rom_addr_o;
  logic [15:0] rom_data_i;

  modport slave (
    input  vid_req_i, vid_addr_i, cpu_req_i, cpu_addr_i, rom_data_i,
    output vid_valid_o, vid_data_o, vid_drop_o, cpu_ack_o, cpu_data_o,
           drop_cnt_o, rom_addr_o
  );

  modport master (
    output vid_req_i, vid_addr_i, cpu_req_i, cpu_addr_i, rom_data_i,
    input  vid_valid_o, vid_data_o, vid_drop_o, cpu_ack_o, cpu_data_o,
           drop_cnt_o, rom_addr_o
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: video has fixed priority, CPU forced in after MAX_WAIT lost cycles.
// Latency: grant and rom_addr combinational; video valid / CPU ack one cycle after grant.
// Backpressure: none on video (a request displaced by a forced CPU slot is dropped); CPU holds req until ack.
module font_rom_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  font_rom_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_ACK  = 2'd2
  } cpu_state_e;

  cpu_state_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [10:0] last_addr_q;
  logic        vid_pend_q;
  logic [15:0] cpu_data_q;
  logic [7:0]  drop_cnt_q;

  logic        cpu_elig;
  logic        cpu_force;
  logic        cpu_gnt;
  logic        vid_gnt;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    // Reset gating keeps the combinational grant path silent while rst_ni is low.
    cpu_elig   = rst_ni && bus.cpu_req_i && (state_q != C_ACK);
    cpu_force  = cpu_elig && (wait_cnt_q == 4'(MAX_WAIT));
    cpu_gnt    = cpu_elig && (cpu_force || !bus.vid_req_i);
    vid_gnt    = rst_ni && bus.vid_req_i && !cpu_gnt;
    case (state_q)
      C_IDLE, C_WAIT: begin
        if (cpu_gnt) begin
          state_d    = C_ACK;
          wait_cnt_d = '0;
        end else if (cpu_elig) begin
          state_d    = C_WAIT;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= C_IDLE;
      wait_cnt_q  <= '0;
      last_addr_q <= '0;
      vid_pend_q  <= 1'b0;
      cpu_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      vid_pend_q <= vid_gnt;
      if (cpu_gnt || vid_gnt) begin
        last_addr_q <= bus.rom_addr_o;
      end
      if (state_q == C_ACK) begin
        cpu_data_q <= bus.rom_data_i;
      end
      if (bus.vid_drop_o && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign bus.rom_addr_o  = cpu_gnt ? bus.cpu_addr_i :
                           vid_gnt ? bus.vid_addr_i : last_addr_q;
  assign bus.vid_drop_o  = cpu_gnt && bus.vid_req_i;
  assign bus.vid_valid_o = vid_pend_q;
  assign bus.vid_data_o  = vid_pend_q ? bus.rom_data_i : '0;
  assign bus.cpu_ack_o   = (state_q == C_ACK);
  assign bus.cpu_data_o  = (state_q == C_ACK) ? bus.rom_data_i : cpu_data_q;
  assign bus.drop_cnt_o  = drop_cnt_q;

endmodule
